// File: rtl/btn_cond_pkg.sv
// Shared types, default timing constants and width helpers for the button conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, press/release debounce FSM and, with AUTO_REPEAT_EN
// defined, a hold-to-repeat counter. Emits a registered one-cycle req per command.
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  input  logic ms_tick_i,
  output logic level_o,
  output logic req_o
);

  localparam int DB_W = cnt_w(DEBOUNCE_MS);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  if (DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_timing
    $error("btn_channel: timing parameters must be >= 1");
  end

  logic [1:0] sync_q;
  logic       pressed;
  ch_state_e  state_q;
  logic [DB_W-1:0] db_q;
  logic       level_q;
  logic       req_q;
  logic       rel_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], btn_n_i};
  end

  always_comb begin
    pressed  = ~sync_q[1];
    rel_done = ~pressed & ms_tick_i & (db_q == DB_LAST);
  end

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = cnt_w(max_int(REPEAT_DELAY_MS, REPEAT_RATE_MS));
  localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY_MS - 1);
  localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE_MS - 1);

  logic [RP_W-1:0] rp_q;
  logic [RP_W-1:0] rp_last;

  always_comb rp_last = (state_q == ST_REPEAT) ? RP_RATE_LAST : RP_DELAY_LAST;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      db_q    <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rp_q    <= '0;
`endif
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!pressed) begin
            db_q <= '0;
          end else if (ms_tick_i) begin
            if (db_q == DB_LAST) begin
              req_q   <= 1'b1;
              level_q <= 1'b1;
              db_q    <= '0;
`ifdef AUTO_REPEAT_EN
              rp_q    <= '0;
`endif
              state_q <= ST_HOLD;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end
        end
        default: begin
          if (pressed)        db_q <= '0;
          else if (ms_tick_i) db_q <= db_q + 1'b1;
          // Release acceptance takes precedence over a repeat expiring on the same tick.
          if (rel_done) begin
            level_q <= 1'b0;
            db_q    <= '0;
`ifdef AUTO_REPEAT_EN
            rp_q    <= '0;
`endif
            state_q <= ST_IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (ms_tick_i) begin
            if (rp_q == rp_last) begin
              req_q   <= 1'b1;
              rp_q    <= '0;
              state_q <= ST_REPEAT;
            end else begin
              rp_q <= rp_q + 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign req_o   = req_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounced pushbutton conditioner: shared 1 ms prescaler, NUM_BTN channels and a
// one-pulse-per-cycle priority arbiter. Optional hold-to-repeat via `define AUTO_REPEAT_EN.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] cmd_pulse,
  output logic [NUM_BTN-1:0] cmd_pulse_n
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TICK_W   = cnt_w(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || (CLK_HZ % 1000) != 0) begin : g_bad_div
    $error("button_conditioner: CLK_HZ/1000 must be an integer >= 2");
  end

  logic [TICK_W-1:0]  presc_q, presc_d;
  logic               ms_tick;
  logic [NUM_BTN-1:0] req_w, level_w;
  logic [NUM_BTN-1:0] pend_q, pend_d, want, grant;
  logic [NUM_BTN-1:0] pulse_q, pulse_n_q;

  always_comb begin
    ms_tick = (presc_q == TICK_LAST);
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_n_i  (btn_n[i]),
      .ms_tick_i(ms_tick),
      .level_o  (level_w[i]),
      .req_o    (req_w[i])
    );
  end

  // Fresh reqs join the pending set the same cycle so an uncontended req pulses next cycle.
  always_comb begin
    want   = pend_q | req_w;
    grant  = want & (~want + 1'b1);
    pend_d = want & ~grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pend_q    <= '0;
      pulse_q   <= '0;
      pulse_n_q <= '1;
    end else begin
      presc_q   <= presc_d;
      pend_q    <= pend_d;
      pulse_q   <= grant;
      pulse_n_q <= ~grant;
    end
  end

  assign btn_level   = level_w;
  assign cmd_pulse   = pulse_q;
  assign cmd_pulse_n = pulse_n_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with TICK_DIV=10, debounce 3, repeat 10/4 ms.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] btn_level, cmd_pulse, cmd_pulse_n;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int onehot_err = 0;
  int pn_err     = 0;

  typedef struct { int c; logic [3:0] v; } ev_t;
  ev_t pq[$];

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  button_conditioner #(
    .NUM_BTN(4), .CLK_HZ(10_000), .DEBOUNCE_MS(3),
    .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_level(btn_level), .cmd_pulse(cmd_pulse), .cmd_pulse_n(cmd_pulse_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release: after edge k the value is k; ms ticks act on multiples of 10.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      pq.delete();
    end else begin
      if (cmd_pulse != 4'b0) begin
        pq.push_back('{c: cyc, v: cmd_pulse});
        if (!$onehot(cmd_pulse)) onehot_err++;
      end
      if (cmd_pulse_n !== ~cmd_pulse) pn_err++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int npulse(input int b, input int lo, input int hi);
    int n = 0;
    foreach (pq[i]) if (pq[i].c >= lo && pq[i].c <= hi && pq[i].v[b]) n++;
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    btn_n = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_level", btn_level, 4'h0);
    chk_eq("rst_pulse", cmd_pulse, 4'h0);
    chk_eq("rst_pulse_n", cmd_pulse_n, 4'hF);
    rst   = 1'b0;
    btn_n = 4'b1110;

    // Clean press on channel 0, released at 200
    wait_cyc(29);  chk_eq("t1_level_pre", btn_level[0], 1'b0);
    wait_cyc(30);  chk_eq("t1_level_on", btn_level[0], 1'b1);
    chk_eq("t1_no_early", npulse(0, 0, 30), 0);
    wait_cyc(31);  chk_eq("t1_pulse", cmd_pulse, 4'b0001);
    chk_eq("t1_pulse_n", cmd_pulse_n, 4'b1110);
    wait_cyc(32);  chk_eq("t1_pulse_end", cmd_pulse, 4'b0000);
    if (AR) begin
      wait_cyc(131); chk_eq("t1_rep1", cmd_pulse, 4'b0001);
    end
    wait_cyc(200); btn_n[0] = 1'b1;
    wait_cyc(229); chk_eq("t1_rel_pre", btn_level[0], 1'b1);
    wait_cyc(230); chk_eq("t1_rel", btn_level[0], 1'b0);
    wait_cyc(260); chk_eq("t1_count", npulse(0, 0, 260), AR ? 4 : 1);

    // Bounce on channel 1: toggles every 15 cycles, never stable for 3 ticks
    for (int k = 0; k < 7; k++) begin
      wait_cyc(300 + 15 * k);
      btn_n[1] = k[0];
    end
    wait_cyc(372); chk_eq("t2_level_mid", btn_level[1], 1'b0);
    wait_cyc(400); btn_n[1] = 1'b1;
    wait_cyc(450); chk_eq("t2_level_end", btn_level[1], 1'b0);
    chk_eq("t2_count", npulse(1, 300, 450), 0);

    // Long hold on channel 2 (300 ticks)
    wait_cyc(500); btn_n[2] = 1'b0;
    wait_cyc(531); chk_eq("t3_first", cmd_pulse, 4'b0100);
    if (AR) begin
      wait_cyc(631); chk_eq("t3_delay", cmd_pulse, 4'b0100);
      wait_cyc(671); chk_eq("t3_rate", cmd_pulse, 4'b0100);
    end
    wait_cyc(3500); btn_n[2] = 1'b1;
    wait_cyc(3529); chk_eq("t3_rel_pre", btn_level[2], 1'b1);
    wait_cyc(3530); chk_eq("t3_rel", btn_level[2], 1'b0);
    wait_cyc(3600);
    chk_eq("t3_count", npulse(2, 500, 3600), AR ? 74 : 1);
    chk_eq("t3_after_rel", npulse(2, 3512, 3600), 0);

    // Simultaneous press on all channels
    wait_cyc(3700); btn_n = 4'h0;
    wait_cyc(3730); chk_eq("t4_level", btn_level, 4'hF);
    chk_eq("t4_none_yet", cmd_pulse, 4'h0);
    wait_cyc(3731); chk_eq("t4_g0", cmd_pulse, 4'b0001);
    wait_cyc(3732); chk_eq("t4_g1", cmd_pulse, 4'b0010);
    wait_cyc(3733); chk_eq("t4_g2", cmd_pulse, 4'b0100);
    wait_cyc(3734); chk_eq("t4_g3", cmd_pulse, 4'b1000);
    chk_eq("t4_g3_n", cmd_pulse_n, 4'b0111);
    wait_cyc(3735); chk_eq("t4_done", cmd_pulse, 4'b0000);
    wait_cyc(3750); btn_n = 4'hF;
    wait_cyc(3780); chk_eq("t4_rel", btn_level, 4'h0);

    // Release whose 3rd debounce tick lands on a repeat expiry (edge 4210)
    wait_cyc(4000); btn_n[0] = 1'b0;
    wait_cyc(4031); chk_eq("t6_first", cmd_pulse, 4'b0001);
    if (AR) begin
      wait_cyc(4171); chk_eq("t6_rep", cmd_pulse, 4'b0001);
    end
    wait_cyc(4185); btn_n[0] = 1'b1;
    wait_cyc(4209); chk_eq("t6_rel_pre", btn_level[0], 1'b1);
    wait_cyc(4210); chk_eq("t6_rel", btn_level[0], 1'b0);
    wait_cyc(4260); chk_eq("t6_no_pulse", npulse(0, 4172, 4260), 0);

    // Reset while channel 0 is held (in REPEAT when auto-repeat is built)
    wait_cyc(4300); btn_n[0] = 1'b0;
    wait_cyc(4331); chk_eq("t5_first", cmd_pulse, 4'b0001);
    wait_cyc(4450);
    #2 rst = 1'b1;
    #1;
    chk_eq("t5_async_level", btn_level, 4'h0);
    chk_eq("t5_async_pulse", cmd_pulse, 4'h0);
    chk_eq("t5_async_pulse_n", cmd_pulse_n, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(29); chk_eq("t5_level_pre", btn_level[0], 1'b0);
    chk_eq("t5_no_early", npulse(0, 0, 29), 0);
    wait_cyc(30); chk_eq("t5_level_on", btn_level[0], 1'b1);
    wait_cyc(31); chk_eq("t5_pulse", cmd_pulse, 4'b0001);
    btn_n[0] = 1'b1;
    wait_cyc(80);

    chk_eq("onehot", onehot_err, 0);
    chk_eq("pulse_n_inv", pn_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
